// File: rtl/ldl_rr_grant_mux_v1.sv
// ldl_rr_grant_mux_v1: selects the granted payload into a 2-entry skid buffer and acks the winner; ports: clk, rst, gnt_valid/gnt_bin/gnt_hot/gnt_ready (grant in), req_data (payloads in), req_ack (ack pulse out), out_valid/out_ready/out_data/out_src (stream out)
module ldl_rr_grant_mux_v1 #(
  parameter int BIN_WIDTH  = 3,
  parameter int REQ_WIDTH  = 1 << BIN_WIDTH,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            gnt_valid,
  input  logic [BIN_WIDTH-1:0]            gnt_bin,
  input  logic [REQ_WIDTH-1:0]            gnt_hot,
  output logic                            gnt_ready,
  input  logic [REQ_WIDTH*DATA_WIDTH-1:0] req_data,
  output logic [REQ_WIDTH-1:0]            req_ack,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic [BIN_WIDTH-1:0]            out_src
);
  logic [1:0]            count, count_next;
  logic [DATA_WIDTH-1:0] head_data, skid_data, sel_data;
  logic [BIN_WIDTH-1:0]  head_src, skid_src;
  logic                  push, pop;
  assign sel_data   = req_data[gnt_bin*DATA_WIDTH +: DATA_WIDTH];
  assign push       = gnt_valid & gnt_ready;
  assign pop        = out_valid & out_ready;
  assign count_next = count + {1'b0, push} - {1'b0, pop};
  assign out_valid  = count != 2'd0;
  assign out_data   = head_data;
  assign out_src    = head_src;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      count     <= '0;
      gnt_ready <= 1'b0;
      req_ack   <= '0;
      head_data <= '0;
      head_src  <= '0;
      skid_data <= '0;
      skid_src  <= '0;
    end else begin
      count     <= count_next;
      gnt_ready <= count_next < 2'd2;
      req_ack   <= push ? gnt_hot : '0;
      if (push && (count == 2'd0 || pop)) begin
        head_data <= sel_data;
        head_src  <= gnt_bin;
      end else if (pop && count == 2'd2) begin
        head_data <= skid_data;
        head_src  <= skid_src;
      end
      if (push && !pop && count == 2'd1) begin
        skid_data <= sel_data;
        skid_src  <= gnt_bin;
      end
    end
`ifndef SYNTHESIS
  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ack));
  a_count_max:  assert property (@(posedge clk) disable iff (rst) count <= 2'd2);
  a_out_stable: assert property (@(posedge clk) disable iff (rst)
    out_valid && !out_ready |=> $stable(out_data) && $stable(out_src));
  a_bin_range:  assert property (@(posedge clk) disable iff (rst)
    !gnt_valid || int'(gnt_bin) < REQ_WIDTH);
`endif
endmodule

// File: tb/tb_ldl_rr_grant_mux_v1.sv
// tb_ldl_rr_grant_mux_v1: scoreboard bench for the grant mux skid buffer
module tb_ldl_rr_grant_mux_v1;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         gnt_valid = 1'b0;
  logic [2:0]   gnt_bin = '0;
  logic [7:0]   gnt_hot = '0;
  logic         gnt_ready;
  logic [255:0] req_data;
  logic [7:0]   req_ack;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic [2:0]   out_src;
  logic [31:0]  pay [8];
  logic [34:0]  q [$];
  logic [7:0]   exp_ack = '0;
  logic         m_rdy = 1'b0;
  logic         last_push = 1'b0;
  int           total = 0;
  int           passed = 0;
  int           vcnt;

  always #5 clk = ~clk;

  always_comb
    for (int i = 0; i < 8; i++) req_data[i*32 +: 32] = pay[i];

  ldl_rr_grant_mux_v1 dut (
    .clk(clk), .rst(rst), .gnt_valid(gnt_valid), .gnt_bin(gnt_bin), .gnt_hot(gnt_hot),
    .gnt_ready(gnt_ready), .req_data(req_data), .req_ack(req_ack), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_src(out_src)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_outputs();
    chk("out_valid", {63'd0, out_valid}, {63'd0, q.size() != 0});
    chk("gnt_ready", {63'd0, gnt_ready}, {63'd0, m_rdy});
    chk("req_ack", {56'd0, req_ack}, {56'd0, exp_ack});
    if (q.size() != 0) begin
      chk("out_data", {32'd0, out_data}, {32'd0, q[0][31:0]});
      chk("out_src", {61'd0, out_src}, {61'd0, q[0][34:32]});
    end
  endtask

  task automatic grant(input bit v, input int b);
    gnt_valid = v;
    gnt_bin   = 3'(b);
    gnt_hot   = 8'(1 << b);
  endtask

  task automatic cycle();
    logic push, pop;
    push = gnt_valid && m_rdy;
    pop  = (q.size() != 0) && out_ready;
    if (pop) void'(q.pop_front());
    if (push) q.push_back({gnt_bin, pay[gnt_bin]});
    exp_ack   = push ? 8'(1 << gnt_bin) : 8'd0;
    m_rdy     = q.size() < 2;
    last_push = push;
    @(posedge clk);
    #1;
    if (out_valid) vcnt++;
    check_outputs();
  endtask

  initial begin
    for (int i = 0; i < 8; i++) pay[i] = 32'hA5A5_0000 | 32'(i);
    #1;
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_ready", {63'd0, gnt_ready}, 64'd0);
    chk("rst_ack", {56'd0, req_ack}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    chk("rst_src", {61'd0, out_src}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cycle();
    out_ready = 1'b1;
    grant(1, 5);
    cycle();
    chk("single_data", {32'd0, out_data}, 64'hA5A5_0005);
    chk("single_ack", {56'd0, req_ack}, 64'h20);
    grant(0, 0);
    cycle();
    out_ready = 1'b0;
    grant(1, 1); cycle();
    grant(1, 2); cycle();
    grant(1, 3); cycle();
    cycle();
    chk("stall_ready", {63'd0, gnt_ready}, 64'd0);
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("stall_ack3", {56'd0, req_ack}, 64'h08);
    grant(0, 0);
    cycle();
    cycle();
    vcnt = 0;
    for (int i = 0; i < 8; i++) begin
      grant(1, i);
      cycle();
    end
    grant(0, 0);
    cycle();
    cycle();
    chk("stream_count", 64'(vcnt), 64'd8);
    grant(1, 6); cycle();
    grant(1, 7); cycle();
    chk("simul_src7", {61'd0, out_src}, 64'd7);
    grant(1, 0); cycle();
    chk("simul_src0", {61'd0, out_src}, 64'd0);
    grant(0, 0); cycle();
    cycle();
    out_ready = 1'b0;
    grant(1, 4); cycle();
    grant(1, 2); cycle();
    grant(1, 1); cycle();
    chk("full_ready", {63'd0, gnt_ready}, 64'd0);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    exp_ack = '0;
    m_rdy   = 1'b0;
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_ready", {63'd0, gnt_ready}, 64'd0);
    chk("mid_rst_data", {32'd0, out_data}, 64'd0);
    chk("mid_rst_src", {61'd0, out_src}, 64'd0);
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
    cycle();
    chk("post_rst_ready", {63'd0, gnt_ready}, 64'd1);
    chk("post_rst_ack", {56'd0, req_ack}, 64'd0);
    grant(0, 0);
    last_push = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      for (int i = 0; i < 8; i++) pay[i] = $urandom;
      if (!gnt_valid || last_push) grant($urandom_range(0, 1) == 1, $urandom_range(0, 7));
      out_ready = $urandom_range(0, 3) != 0;
      cycle();
    end
    grant(0, 0);
    out_ready = 1'b1;
    cycle();
    cycle();
    chk("drain_empty", {63'd0, out_valid}, 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
